// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a one-entry skid buffer, a registered ready
// and a saturating backpressure counter.
module ex_mem_skid_stage #(
  parameter int REG_WIDTH  = 32,
  parameter int CTRL_WIDTH = 22,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  cnt_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_WIDTH-1:0]  in_alu_out,
  input  logic [REG_WIDTH-1:0]  in_dataB,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_reg_write_en,
  input  logic                  in_mem_write_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_WIDTH-1:0]  out_alu_out,
  output logic [REG_WIDTH-1:0]  out_dataB,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_reg_write_en,
  output logic                  out_mem_write_en,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0]  alu_out;
    logic [REG_WIDTH-1:0]  data_b;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  reg_write_en;
    logic                  mem_write_en;
  } entry_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   in_fire;
  logic   out_fire;

  assign in_entry = '{alu_out: in_alu_out, data_b: in_dataB, ctrl: in_ctrl,
                      reg_write_en: in_reg_write_en, mem_write_en: in_mem_write_en};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // in_ready and out_valid are flops updated alongside the state, so neither
  // has a combinational path from the opposite side of the stage.
  // NOTE: every register here uses <= so all flops sample pre-edge values;
  // blocking assignments would make the main/skid swap order-dependent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      // NOTE: payload flops are reset too, so out_* read 0 straight out of
      // reset rather than X; this costs reset fan-out but keeps MEM clean.
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q    <= in_entry;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (in_fire) begin
            skid_q   <= in_entry;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_alu_out      = main_q.alu_out;
  assign out_dataB        = main_q.data_b;
  assign out_ctrl         = main_q.ctrl;
  assign out_reg_write_en = main_q.reg_write_en & out_valid;
  assign out_mem_write_en = main_q.mem_write_en & out_valid;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Directed bench for ex_mem_skid_stage: streaming, backpressure, flush,
// counter saturation (second instance with a 2-bit counter) and async reset.
module tb_ex_mem_skid_stage;

  localparam int RW = 32;
  localparam int CW = 22;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          cnt_clr;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_alu_out;
  logic [RW-1:0] in_dataB;
  logic [CW-1:0] in_ctrl;
  logic          in_reg_write_en;
  logic          in_mem_write_en;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_alu_out;
  logic [RW-1:0] out_dataB;
  logic [CW-1:0] out_ctrl;
  logic          out_reg_write_en;
  logic          out_mem_write_en;
  logic [15:0]   stall_cnt;

  logic          in_ready2;
  logic          out_valid2;
  logic [RW-1:0] out_alu_out2;
  logic [RW-1:0] out_dataB2;
  logic [CW-1:0] out_ctrl2;
  logic          out_reg_write_en2;
  logic          out_mem_write_en2;
  logic [1:0]    stall_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_out(in_alu_out),
    .in_dataB(in_dataB), .in_ctrl(in_ctrl), .in_reg_write_en(in_reg_write_en),
    .in_mem_write_en(in_mem_write_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_out(out_alu_out), .out_dataB(out_dataB), .out_ctrl(out_ctrl),
    .out_reg_write_en(out_reg_write_en), .out_mem_write_en(out_mem_write_en),
    .stall_cnt(stall_cnt)
  );

  ex_mem_skid_stage #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(in_ready2), .in_alu_out(in_alu_out),
    .in_dataB(in_dataB), .in_ctrl(in_ctrl), .in_reg_write_en(in_reg_write_en),
    .in_mem_write_en(in_mem_write_en), .out_valid(out_valid2), .out_ready(out_ready),
    .out_alu_out(out_alu_out2), .out_dataB(out_dataB2), .out_ctrl(out_ctrl2),
    .out_reg_write_en(out_reg_write_en2), .out_mem_write_en(out_mem_write_en2),
    .stall_cnt(stall_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] alu, input logic [RW-1:0] db,
                       input logic [CW-1:0] ctrl, input logic rwe, input logic mwe);
    in_valid        = v;
    in_alu_out      = alu;
    in_dataB        = db;
    in_ctrl         = ctrl;
    in_reg_write_en = rwe;
    in_mem_write_en = mwe;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #12;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++;
    if (out_alu_out !== '0 || out_dataB !== '0 || out_ctrl !== '0) begin
      failures++; $display("FAIL reset_payload: got alu=%h db=%h ctrl=%h want 0", out_alu_out, out_dataB, out_ctrl);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, RW'(i), RW'(i + 100), CW'(i * 7), 1'b1, 1'b0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_alu_out !== RW'(i)) begin
        failures++; $display("FAIL stream_out_%0d: got valid=%b alu=%h want valid=1 alu=%h", i, out_valid, out_alu_out, RW'(i));
      end
      checks++;
      if (out_ctrl !== CW'(i * 7) || out_dataB !== RW'(i + 100) || out_reg_write_en !== 1'b1) begin
        failures++; $display("FAIL stream_side_%0d: got ctrl=%h db=%h rwe=%b", i, out_ctrl, out_dataB, out_reg_write_en);
      end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready_%0d: got %b want 1", i, in_ready); end
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'hA10, 22'h11, 1'b1, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'h10 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL bp_a_accept: got valid=%b alu=%h rdy=%b cnt=%0d want 1 10 1 0", out_valid, out_alu_out, in_ready, stall_cnt);
    end
    drive(1'b1, 32'h20, 32'hA20, 22'h22, 1'b0, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_alu_out !== 32'h10 || stall_cnt !== 16'd1) begin
      failures++; $display("FAIL bp_full: got rdy=%b alu=%h cnt=%0d want 0 10 1", in_ready, out_alu_out, stall_cnt);
    end
    drive(1'b0, 32'hDEAD, '0, '0, 1'b0, 1'b0);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_alu_out !== 32'h10 || out_dataB !== 32'hA10 || stall_cnt !== 16'd2) begin
      failures++; $display("FAIL bp_hold: got rdy=%b alu=%h db=%h cnt=%0d want 0 10 a10 2", in_ready, out_alu_out, out_dataB, stall_cnt);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'h20 || out_ctrl !== 22'h22 || in_ready !== 1'b1 || stall_cnt !== 16'd2) begin
      failures++; $display("FAIL bp_second: got valid=%b alu=%h ctrl=%h rdy=%b cnt=%0d want 1 20 22 1 2", out_valid, out_alu_out, out_ctrl, in_ready, stall_cnt);
    end
    checks++;
    if (out_reg_write_en !== 1'b0 || out_mem_write_en !== 1'b1) begin
      failures++; $display("FAIL bp_second_we: got rwe=%b mwe=%b want 0 1", out_reg_write_en, out_mem_write_en);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_mem_write_en !== 1'b0) begin
      failures++; $display("FAIL bp_empty_we: got valid=%b mwe=%b want 0 0", out_valid, out_mem_write_en);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h30, '0, '0, 1'b0, 1'b1);
    step();
    drive(1'b1, 32'h40, '0, '0, 1'b0, 1'b1);
    step();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_prefull: got rdy=%b want 0", in_ready); end
    drive(1'b1, 32'h50, '0, '0, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_mem_write_en !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_result: got valid=%b mwe=%b rdy=%b want 0 0 1", out_valid, out_mem_write_en, in_ready);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_reappear: got valid=%b alu=%h want valid 0", out_valid, out_alu_out); end
    drive(1'b1, 32'h60, '0, '0, 1'b1, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'h60) begin
      failures++; $display("FAIL flush_after: got valid=%b alu=%h want 1 60", out_valid, out_alu_out);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_cnt_sat();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL sat_clear_start: got cnt2=%0d cnt=%0d want 0 0", stall_cnt2, stall_cnt);
    end
    out_ready = 1'b0;
    drive(1'b1, 32'h70, '0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if (stall_cnt2 !== 2'((i > 3) ? 3 : i)) begin
        failures++; $display("FAIL sat_cnt2_%0d: got %0d want %0d", i, stall_cnt2, (i > 3) ? 3 : i);
      end
    end
    checks++;
    if (stall_cnt !== 16'd6) begin failures++; $display("FAIL sat_cnt16: got %0d want 6", stall_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin
      failures++; $display("FAIL sat_clr_wins: got cnt2=%0d cnt=%0d want 0 0", stall_cnt2, stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    // Stage still holds 0x70 with out_ready=0; add 0x80 to reach FULL.
    drive(1'b1, 32'h80, '0, '0, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_prefull: got rdy=%b want 0", in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0 || out_alu_out !== '0 || out_reg_write_en !== 1'b0) begin
      failures++; $display("FAIL areset_immediate: got valid=%b rdy=%b cnt=%0d alu=%h rwe=%b", out_valid, in_ready, stall_cnt, out_alu_out, out_reg_write_en);
    end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h90, '0, '0, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_alu_out !== 32'h90) begin
      failures++; $display("FAIL areset_first: got valid=%b alu=%h want 1 90", out_valid, out_alu_out);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL areset_alone: got valid=%b alu=%h want valid 0", out_valid, out_alu_out);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_cnt_sat();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_stage.md
EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32: width of ALU result and store data.
REQ-002 SHALL have parameter CTRL_WIDTH, default 22: opaque sideband width (opcode, rs1, rs2, rd).
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the stall counter.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-008 in_valid  input  1  EX presents a valid entry.
REQ-009 in_ready  output  1  stage accepts an entry this cycle; registered.
REQ-010 in_alu_out  input  REG_WIDTH  ALU result.
REQ-011 in_dataB  input  REG_WIDTH  store data.
REQ-012 in_ctrl  input  CTRL_WIDTH  sideband, carried unmodified.
REQ-013 in_reg_write_en  input  1  register-file write enable.
REQ-014 in_mem_write_en  input  1  data-memory write enable.
REQ-015 out_valid  output  1  head entry valid toward MEM.
REQ-016 out_ready  input  1  MEM consumes head entry this cycle.
REQ-017 out_alu_out / out_dataB  output  REG_WIDTH each  head entry payload.
REQ-018 out_ctrl  output  CTRL_WIDTH  head entry sideband.
REQ-019 out_reg_write_en / out_mem_write_en  output  1 each  head enables, ANDed with out_valid.
REQ-020 stall_cnt  output  CNT_WIDTH  count of backpressured cycles.

Function
REQ-021 SHALL hold two entry registers, main (drives out_*) and skid, with 3-state FSM EMPTY, ONE, FULL.
REQ-022 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-023 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; in_ready SHALL be 0 only in FULL.
REQ-024 EMPTY: in_fire -> main<=in, ONE; else stay.
REQ-025 ONE: in_fire & out_fire -> main<=in, stay ONE; in_fire & ~out_ready -> skid<=in, FULL; ~in_fire & out_fire -> EMPTY.
REQ-026 FULL: out_fire -> main<=skid, ONE; else hold both entries.
REQ-027 Latency: in_fire in EMPTY or ONE-with-out_fire SHALL give out_valid=1 with that payload the next cycle.
REQ-028 Entries SHALL leave in acceptance order; none dropped or duplicated without flush.
REQ-029 flush SHALL override all transitions: next state EMPTY, entries accepted in the flush cycle discarded, out_valid=0 and in_ready=1 next cycle.
REQ-030 Payload registers need not clear on flush; out_*_write_en SHALL read 0 whenever out_valid=0.
REQ-031 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_WIDTH-1.
REQ-032 cnt_clr SHALL set stall_cnt to 0 next cycle, winning over a same-cycle increment.

Reset
REQ-033 reset_n low SHALL immediately force state EMPTY, out_valid=0, in_ready=1, stall_cnt=0, all payload registers 0, independent of clk.
REQ-034 Reset asserted mid-operation SHALL discard both entries; first post-reset edge behaves as EMPTY.

Verification
REQ-035 Streaming: out_ready=1, in_alu_out=1,2,3 on consecutive cycles -> out_alu_out=1,2,3 one cycle later, in_ready stays 1.
REQ-036 Backpressure: out_ready=0, send A=0x10, B=0x20 -> FULL, in_ready=0, stall_cnt increments; out_ready=1 -> 0x10 then 0x20.
REQ-037 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_mem_write_en=0, in_ready=1; no old entry reappears.
REQ-038 CNT_WIDTH=2, out_ready=0 for 6 cycles with out_valid=1 -> stall_cnt saturates at 3; cnt_clr=1 -> 0.
REQ-039 reset_n low between clock edges while FULL -> outputs at reset values at once; entry after release appears alone.
